bcd_secuencial: RTL and testbench
=================================

Name: bcd_secuencial

Overview:
- Sequential binary-to-BCD converter using shift-add-3 (double dabble), one bit per clock.
- Sits directly downstream of the echo counter stage. It latches the binary `count` on the counter's `calculate` strobe.
- It delivers hundreds/tens/units digits plus leading-zero significance flags to the display multiplexer (conmutacion).
- Outputs are registered and held stable between conversions, so the display never shows intermediate values.

Parameters:
W, 8, width of binary input count
ND, 3, number of BCD digits produced (units, tens, hundreds; ND fixed at 3 for port widths, kept as parameter for overflow check)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
count  in  W  binary value to convert, sampled only on accepted start
calculate  in  1  start strobe from counter, sampled high for one or more cycles
centenas  out  4  hundreds BCD digit
decenas  out  4  tens BCD digit
unidades  out  4  units BCD digit
C  out  1  hundreds digit significant (not a leading zero)
De  out  1  tens digit significant
U  out  1  units digit shown (always 1 after first valid result)
valid  out  1  one-cycle pulse: new result on digit outputs
busy  out  1  conversion in progress
lost  out  1  one-cycle pulse: calculate rejected while busy
ovf  out  1  result exceeded 10^ND-1; digits saturated to 9

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; all digits 0; C=De=U=0; valid=busy=lost=ovf=0; shift register and iteration counter cleared.
- Reset asserted mid-conversion aborts immediately. No valid pulse follows. Outputs take reset values.
- FSM states: IDLE, SHIFT, DONE.
- IDLE with calculate=1 at edge k:
  - load shift register: BCD field 0, binary field = count;
  - iteration counter = 0;
  - go to SHIFT; busy=1 from edge k.
- Calculate held high across several cycles counts as one start. A new start requires calculate to return low first (edge detect on calculate).
- SHIFT, each cycle:
  - every 4-bit BCD field >=5 gets +3 (combinational);
  - then the whole register shifts left by 1;
  - counter increments;
  - after the W-th shift (edge k+W), go to DONE.
- DONE (edge k+W+1):
  - register digits into outputs;
  - compute C, De, U and ovf;
  - valid=1 for exactly this cycle;
  - busy falls to 0 with valid;
  - return to IDLE.
- Latency: calculate sampled at edge k -> valid high and outputs updated at edge k+W+1. For W=8 that is 9 cycles.
- Significance flags:
  - C = (centenas!=0);
  - De = C or (decenas!=0);
  - U = 1.
- Overflow:
  - internal BCD register has enough digits to hold 2^W-1;
  - if any digit above ND is nonzero, ovf=1 and centenas/decenas/unidades = 9/9/9, C=De=U=1;
  - ovf is cleared on the next non-overflow result;
  - W=8/ND=3 can never overflow.
- Calculate rising edge while busy=1 (SHIFT or DONE): ignored; lost=1 for one cycle; conversion in progress unaffected.
- Count changing during SHIFT has no effect. Only the value at the start edge is converted.
- Outputs other than valid/lost/busy hold their value until the next DONE.

Decomposition:
- Shared package:
  - FSM state encodings ST_IDLE/ST_SHIFT/ST_DONE (2-bit);
  - BCD_NINE constant;
  - iteration-counter width derived as clog2(W+1).
- One sub-module: bcd_ajuste. It is a combinational 4-bit in/4-bit out add-3-if->=5 cell, instantiated once per internal BCD digit.

Test Plan:
- count=255, one-cycle calculate -> exactly 9 cycles later valid=1 for one cycle; centenas=2, decenas=5, unidades=5; C=1, De=1, U=1; ovf=0.
- count=7 -> 0/0/7, C=0, De=0, U=1. Then count=0 -> 0/0/0, C=0, De=0, U=1. Then count=40 -> 0/4/0, C=0, De=1.
- Convert 128, then pulse calculate 3 cycles after the start -> lost=1 for one cycle; single valid with 1/2/8; no second valid. Also check that calculate held high for 12 cycles produces only one conversion.
- Start a conversion of 200, drop reset at cycle 4 for one cycle, release -> all outputs 0, busy=0, no valid. A fresh start with 99 then yields 0/9/9 at latency 9.
- Parameter override W=10 (latency 11): count=999 -> 9/9/9, ovf=0; count=1000 -> 9/9/9, ovf=1; count=1023 -> ovf=1; then count=5 -> 0/0/5, ovf=0.
- Back-to-back operation: new start one cycle after valid -> accepted, lost=0, second result correct. Sweep all 256 values of count against a reference model.

Source files
------------

// File: rtl/bcd_secuencial_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encoding, BCD constants and width helper functions.
package bcd_secuencial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [3:0] BCD_NINE = 4'd9;

    // Iteration counter must be able to hold 0..w.
    function automatic int iter_width(input int w);
        return (w < 1) ? 1 : $clog2(w + 1);
    endfunction

    // Number of decimal digits needed to hold 2^w-1, never fewer than nd.
    function automatic int bcd_digits(input int w, input int nd);
        longint v;
        int     n;
        v = (longint'(1) << w) - 1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (v > 0) begin
                v = v / 10;
                n++;
            end
        end
        return (n < nd) ? nd : n;
    endfunction

endpackage

// File: rtl/bcd_ajuste.sv
// Double-dabble correction cell: add 3 to a BCD digit that is 5 or more,
// so the following left shift carries correctly into the next digit.
module bcd_ajuste (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Add-3 correction applied before every shift
    always_comb begin
        dout = din;
        if (din >= 4'd5)
            dout = din + 4'd3;
    end

endmodule

// File: rtl/bcd_secuencial.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock).
// Latches count on a rising edge of calculate, produces hundreds/tens/units
// plus leading-zero flags; outputs are held between conversions.
module bcd_secuencial
    import bcd_secuencial_pkg::*;
#(
    parameter int W  = 8,
    parameter int ND = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] count,
    input  logic         calculate,
    output logic [3:0]   centenas,
    output logic [3:0]   decenas,
    output logic [3:0]   unidades,
    output logic         C,
    output logic         De,
    output logic         U,
    output logic         valid,
    output logic         busy,
    output logic         lost,
    output logic         ovf
);

    localparam int CW  = iter_width(W);
    localparam int NBD = bcd_digits(W, ND);   // internal digits, holds 2^W-1
    localparam int SW  = 4 * NBD + W;          // {bcd digits, binary}

    state_t          state, state_nx;
    logic [SW-1:0]   sr;
    logic [SW-1:0]   shifted;
    logic            shift_unused;             // MSB of a full-scale register is always 0
    logic [4*NBD-1:0] adj;
    logic [CW-1:0]   iter;
    logic            calc_q;
    logic            rise;

    logic            hi_nz;
    logic [3:0]      res_c, res_d, res_u;
    logic            res_C, res_De;

    assign rise = calculate & ~calc_q;

    // One correction cell per internal BCD digit
    for (genvar g = 0; g < NBD; g++) begin : g_adj
        bcd_ajuste u_adj (
            .din  (sr[W+4*g +: 4]),
            .dout (adj[4*g +: 4])
        );
    end

    assign {shift_unused, shifted} = {adj, sr[W-1:0], 1'b0};

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // Next-state: start on calculate edge, W shifts, one DONE cycle
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (rise) state_nx = ST_SHIFT;
            ST_SHIFT: if (iter == CW'(W - 1)) state_nx = ST_DONE;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Result decode with saturation when digits above ND are populated
    always_comb begin
        hi_nz = 1'b0;
        for (int i = ND; i < NBD; i++)
            hi_nz = hi_nz | (sr[W+4*i +: 4] != 4'd0);
        res_u = sr[W   +: 4];
        res_d = sr[W+4 +: 4];
        res_c = sr[W+8 +: 4];
        if (hi_nz) begin
            res_u = BCD_NINE;
            res_d = BCD_NINE;
            res_c = BCD_NINE;
        end
        res_C  = res_c != 4'd0;
        res_De = res_C | (res_d != 4'd0);
    end

    // Datapath, status pulses and held result registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr       <= '0;
            iter     <= '0;
            calc_q   <= 1'b0;
            centenas <= 4'd0;
            decenas  <= 4'd0;
            unidades <= 4'd0;
            C        <= 1'b0;
            De       <= 1'b0;
            U        <= 1'b0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            lost     <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            calc_q <= calculate;
            valid  <= 1'b0;
            lost   <= rise && (state != ST_IDLE);
            busy   <= (state_nx != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (rise) begin
                        sr   <= {{(4*NBD){1'b0}}, count};
                        iter <= '0;
                    end
                end
                ST_SHIFT: begin
                    sr   <= shifted;
                    iter <= iter + CW'(1);
                end
                ST_DONE: begin
                    centenas <= res_c;
                    decenas  <= res_d;
                    unidades <= res_u;
                    C        <= res_C;
                    De       <= res_De;
                    U        <= 1'b1;
                    ovf      <= hi_nz;
                    valid    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_secuencial.sv
// Directed + randomized bench for bcd_secuencial (W=8 and W=10 instances),
// checked against an arithmetic decimal-digit reference model.
module tb_bcd_secuencial;

    logic       clk = 1'b0;
    logic       reset = 1'b0;

    logic [7:0] count8 = '0;
    logic       calc8 = 1'b0;
    logic [3:0] cen8, dec8, uni8;
    logic       C8, De8, U8, valid8, busy8, lost8, ovf8;

    logic [9:0] count10 = '0;
    logic       calc10 = 1'b0;
    logic [3:0] cen10, dec10, uni10;
    logic       C10, De10, U10, valid10, busy10, lost10, ovf10;

    int checks = 0;
    int failures = 0;

    // observations from the last run
    int          nval, nlost, vat, lost_at;
    logic        busy0, busyv;
    logic [15:0] cap;

    always #5 clk = ~clk;

    bcd_secuencial #(.W(8), .ND(3)) dut8 (
        .clk(clk), .reset(reset), .count(count8), .calculate(calc8),
        .centenas(cen8), .decenas(dec8), .unidades(uni8),
        .C(C8), .De(De8), .U(U8),
        .valid(valid8), .busy(busy8), .lost(lost8), .ovf(ovf8)
    );

    bcd_secuencial #(.W(10), .ND(3)) dut10 (
        .clk(clk), .reset(reset), .count(count10), .calculate(calc10),
        .centenas(cen10), .decenas(dec10), .unidades(uni10),
        .C(C10), .De(De10), .U(U10),
        .valid(valid10), .busy(busy10), .lost(lost10), .ovf(ovf10)
    );

    // Reference: {ovf, C, De, U, hundreds, tens, units}
    function automatic logic [15:0] model(input int v);
        int c, d, u;
        logic o, fc, fd;
        o = (v > 999);
        if (o) begin
            c = 9; d = 9; u = 9;
        end else begin
            c = v / 100; d = (v / 10) % 10; u = v % 10;
        end
        fc = (c != 0);
        fd = fc || (d != 0);
        return {o, fc, fd, 1'b1, 4'(c), 4'(d), 4'(u)};
    endfunction

    function automatic logic [17:0] outs8();
        return {cen8, dec8, uni8, C8, De8, U8, valid8, busy8, lost8, ovf8};
    endfunction

    function automatic logic [17:0] outs10();
        return {cen10, dec10, uni10, C10, De10, U10, valid10, busy10, lost10, ovf10};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one start (edge i=0) and watch ncyc edges; calculate is high for
    // the first `hold` edges and again at edge pulse_at. count is scrambled
    // after the start edge.
    task automatic run(input bit wide, input int v, input int hold,
                       input int pulse_at, input int ncyc);
        nval = 0; nlost = 0; vat = -1; lost_at = -1;
        busy0 = 1'bx; busyv = 1'bx; cap = 'x;
        for (int i = 0; i < ncyc; i++) begin
            if (wide) begin
                count10 = (i == 0) ? 10'(v) : 10'($urandom);
                calc10  = (i < hold) || (i == pulse_at);
            end else begin
                count8 = (i == 0) ? 8'(v) : 8'($urandom);
                calc8  = (i < hold) || (i == pulse_at);
            end
            tick();
            if (wide) begin
                if (i == 0) busy0 = busy10;
                if (valid10) begin
                    nval++; vat = i; busyv = busy10;
                    cap = {ovf10, C10, De10, U10, cen10, dec10, uni10};
                end
                if (lost10) begin nlost++; lost_at = i; end
            end else begin
                if (i == 0) busy0 = busy8;
                if (valid8) begin
                    nval++; vat = i; busyv = busy8;
                    cap = {ovf8, C8, De8, U8, cen8, dec8, uni8};
                end
                if (lost8) begin nlost++; lost_at = i; end
            end
        end
        calc8 = 1'b0;
        calc10 = 1'b0;
    endtask

    task automatic chk_run(input string tag, input bit wide, input int v, input int exp_lost);
        chk({tag, ":nval"}, nval, 1);
        chk({tag, ":lat"}, vat, wide ? 11 : 9);
        chk({tag, ":res"}, cap, model(v));
        chk({tag, ":busy0"}, busy0, 1);
        chk({tag, ":busyv"}, busyv, 0);
        chk({tag, ":nlost"}, nlost, exp_lost);
    endtask

    initial begin
        int v;
        // reset state
        reset = 1'b0;
        repeat (3) tick();
        chk("rst8", outs8(), 0);
        chk("rst10", outs10(), 0);
        reset = 1'b1;
        tick();
        chk("idle8", outs8(), 0);

        // directed values, one-cycle strobe
        run(0, 255, 1, -1, 12); chk_run("c255", 0, 255, 0);
        run(0, 7,   1, -1, 12); chk_run("c7",   0, 7,   0);
        chk("hold7", {cen8, dec8, uni8}, 12'h007);
        run(0, 0,   1, -1, 12); chk_run("c0",   0, 0,   0);
        run(0, 40,  1, -1, 12); chk_run("c40",  0, 40,  0);

        // rejected restart three cycles into the conversion
        run(0, 128, 1, 3, 20); chk_run("c128lost", 0, 128, 1);
        chk("lost_at", lost_at, 3);

        // calculate held for 12 cycles -> single conversion
        v = $urandom_range(0, 255);
        run(0, v, 12, -1, 25); chk_run("held12", 0, v, 0);

        // reset mid-conversion
        count8 = 8'd200; calc8 = 1'b1;
        tick();
        calc8 = 1'b0;
        count8 = 8'd0;
        repeat (3) tick();
        chk("busy_mid", busy8, 1);
        reset = 1'b0;
        #1;
        chk("abort_outs", outs8(), 0);
        tick();
        reset = 1'b1;
        nval = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (valid8) nval++;
        end
        chk("abort_noval", nval, 0);
        chk("abort_hold", outs8(), 0);
        run(0, 99, 1, -1, 12); chk_run("c99", 0, 99, 0);

        // W=10 saturation behaviour
        run(1, 999,  1, -1, 14); chk_run("w10_999",  1, 999,  0);
        run(1, 1000, 1, -1, 14); chk_run("w10_1000", 1, 1000, 0);
        run(1, 1023, 1, -1, 14); chk_run("w10_1023", 1, 1023, 0);
        run(1, 5,    1, -1, 14); chk_run("w10_5",    1, 5,    0);
        v = $urandom_range(0, 1023);
        run(1, v,    1, -1, 14); chk_run("w10_rnd",  1, v,    0);

        // back-to-back sweep: each start one cycle after the previous valid
        run(0, 0, 1, -1, 10); chk_run("b2b_first", 0, 0, 0);
        for (int k = 255; k >= 0; k--) begin
            run(0, k, 1, -1, 10);
            chk_run($sformatf("sweep%0d", k), 0, k, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
